// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor (a - b, LSB first, one bit per clock) with an IDLE/SHIFT/DONE controller.
// Optional zero-result flag output enabled by defining SERIAL_SUB_ZERO_FLAG_EN.

module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bor,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr;
  logic [CNT_W-1:0]   cnt;
  logic               br;
  logic               d_bit, d1, bo1, bo2, br_nxt;
  logic               last_bit;
  logic [WIDTH-1:0]   diff_nxt;

  // Full subtractor: two half subtractors plus the borrow OR.
  half_sub u_hs0 (.x(a_sr[0]), .y(b_sr[0]), .d(d1),    .bo(bo1));
  half_sub u_hs1 (.x(d1),      .y(br),      .d(d_bit), .bo(bo2));
  assign br_nxt   = bo1 | bo2;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign diff_nxt = {d_bit, diff[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Operands are captured only on the accepting edge; afterwards a/b are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bor  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            cnt  <= '0;
            br   <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          diff <= diff_nxt;
          if (last_bit) bor <= br_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          zero <= 1'b0;
    else if (state == SHIFT && last_bit) zero <= (diff_nxt == '0);
  end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.
// Honours SERIAL_SUB_ZERO_FLAG_EN when it is defined for the build.

module tb_serial_sub_ctrl;

  typedef struct {
    logic [8:0] res;
    int         due;
  } exp8_t;

  typedef struct {
    logic [4:0] res;
    int         due;
  } exp4_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       bor8, busy8, done8, bor4, busy4, done4;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic       zero8, zero4;
`endif

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  exp8_t q8[$];
  exp4_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .bor(bor8), .busy(busy8), .done(done8)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(zero8)
`endif
  );

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .bor(bor4), .busy(busy4), .done(done4)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(zero4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("spurious_done8", 1, 0);
      else begin
        exp8_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.res[7:0]));
        chk("bor8", 32'(bor8), 32'(e.res[8]));
        chk("done8_cycle", cyc, e.due);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk("zero8", 32'(zero8), 32'(e.res[7:0] == 8'h00));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) chk("spurious_done4", 1, 0);
      else begin
        exp4_t e;
        e = q4.pop_front();
        chk("sweep4", 32'({bor4, diff4}), 32'(e.res));
        chk("done4_cycle", cyc, e.due);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk("zero4", 32'(zero4), 32'(e.res[3:0] == 4'h0));
`endif
      end
    end
  end

  // Called at a falling edge: accepted on the next rising edge, returns one falling edge later.
  task automatic drive_op8(input logic [7:0] av, input logic [7:0] bv);
    exp8_t e;
    start8 = 1'b1; a8 = av; b8 = bv;
    e.res = {1'b0, av} - {1'b0, bv};
    e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drive_op4(input logic [3:0] av, input logic [3:0] bv);
    exp4_t e;
    start4 = 1'b1; a4 = av; b4 = bv;
    e.res = {1'b0, av} - {1'b0, bv};
    e.due = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic wait_idle8(input int limit);
    int n = 0;
    while (!(q8.size() == 0 && !busy8 && !done8) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("timeout8", 0, 1);
  endtask

  task automatic wait_idle4(input int limit);
    int n = 0;
    while (!(q4.size() == 0 && !busy4 && !done4) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("timeout4", 0, 1);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bor", 32'(bor8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk("rst_zero", 32'(zero8), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic case with busy/done timing.
    drive_op8(8'h5A, 8'h3C);
    for (int k = 0; k < 8; k++) begin
      chk("busy_shift", 32'(busy8), 1);
      chk("done_low", 32'(done8), 0);
      @(negedge clk);
    end
    chk("busy_in_done", 32'(busy8), 0);
    chk("done_high", 32'(done8), 1);
    wait_idle8(40);
    repeat (3) @(negedge clk);
    chk("hold_diff", 32'(diff8), 32'h1E);
    chk("hold_bor", 32'(bor8), 0);

    // Borrow and zero-result boundaries.
    drive_op8(8'h00, 8'h01);
    wait_idle8(40);
    drive_op8(8'hFF, 8'hFF);
    wait_idle8(40);
    drive_op8(8'h80, 8'h7F);
    wait_idle8(40);

    // Start and operand changes during SHIFT must be ignored.
    drive_op8(8'h10, 8'h01);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    wait_idle8(40);
    repeat (12) @(negedge clk);
    chk("no_restart", 32'(busy8), 0);

    // Mid-operation reset aborts with no done.
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_diff", 32'(diff8), 0);
    chk("arst_bor", 32'(bor8), 0);
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_done", 32'(done8), 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    chk("arst_zero", 32'(zero8), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_op8(8'h03, 8'h05);
    wait_idle8(40);

    // Back-to-back with start held high: done every WIDTH+2 cycles.
    c0 = cyc;
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    for (int k = 0; k < 3; k++) begin
      exp8_t e;
      e.res = {1'b0, 8'h33} - {1'b0, 8'h44};
      e.due = c0 + 1 + 8 + k * 10;
      q8.push_back(e);
    end
    repeat (21) @(negedge clk);
    start8 = 1'b0;
    wait_idle8(60);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      drive_op4(iv[7:4], iv[3:0]);
      wait_idle4(20);
    end

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-007 diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-008 bor  output  1  registered final borrow: 1 when a<b unsigned.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle completion pulse.

Function
REQ-011 The block SHALL compute a-b bit-serially, LSB first, one bit per clock, using two half_sub instances plus an OR gate as a full subtractor and one borrow flip-flop.
REQ-012 Per bit: d = a_i^b_i^br; br_next = (~a_i&b_i) | (~(a_i^b_i)&br).
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 at a rising edge SHALL load a and b into shift registers, clear the borrow flip-flop and bit counter, and move to SHIFT; start=0 SHALL keep IDLE.
REQ-015 SHIFT: each edge SHALL consume one operand bit, shift d into the result register from the MSB end, and increment the counter.
REQ-016 After the WIDTH-th SHIFT edge, the FSM SHALL enter DONE, diff SHALL hold the full result and bor SHALL hold br_next of the MSB.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge 0, done SHALL be high for exactly the cycle between edges WIDTH and WIDTH+1.
REQ-019 busy SHALL be 1 exactly while in SHIFT and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 exactly while in DONE.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored; the operands are not queued.
REQ-022 a and b SHALL NOT be sampled outside the accepting edge; changes during SHIFT SHALL not affect the result.
REQ-023 diff and bor SHALL hold their last completed values from DONE until the next completion.
REQ-024 diff SHALL show partial, shifting contents during SHIFT and is valid only when done=1 or afterwards in IDLE.
REQ-025 Counter wrap: the counter SHALL be wide enough for WIDTH and SHALL never wrap inside one operation.

Reset
REQ-026 rst_n=0 SHALL force, asynchronously, state=IDLE, counter=0, borrow flip-flop=0, operand registers=0, diff=0, bor=0, busy=0 and done=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept a new start on the first edge.

Configuration
REQ-028 Macro SERIAL_SUB_ZERO_FLAG_EN SHALL control an extra output port zero (1 bit).
REQ-029 With the macro defined, zero SHALL be registered together with diff at completion, equal 1 if and only if the completed diff==0, reset to 0, and hold like diff.
REQ-030 Without the macro, the zero port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x3C, start one cycle -> busy for 8 cycles, then done one cycle with diff=0x1E and bor=0.
REQ-032 a=0x00, b=0x01 -> diff=0xFF, bor=1 at done; a=0xFF, b=0xFF -> diff=0x00, bor=0, and zero=1 when SERIAL_SUB_ZERO_FLAG_EN is defined.
REQ-033 Start a=0x10, b=0x01; during SHIFT pulse start with a=0x00, b=0x01 and change a/b -> single done with diff=0x0F, bor=0, and no second operation.
REQ-034 Start any operation and drop rst_n at cycle 4 -> all outputs 0 immediately, no done; after release, a=0x03, b=0x05 -> diff=0xFE, bor=1.
REQ-035 Back-to-back: hold start high continuously -> a new operation is accepted on the edge in IDLE following each DONE, giving a done every WIDTH+2 cycles.
REQ-036 Exhaustive sweep, WIDTH=4: all 256 a/b pairs -> {bor,diff} matches a golden 5-bit a-b on every pair.
